spi_slave_rx_bridge: RTL and testbench
======================================

SPI_SLAVE_RX_BRIDGE -- requirements
Module: spi_slave_rx_bridge

Interface
REQ-001 SHALL have parameter PACK_LENGTH, default 8, word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter FIFO_DEPTH_LOG_2, default $clog2(FIFO_DEPTH), pointer width.
REQ-004 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port IN_RESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port IN_SPI_CS  input  1  slave chip select, asynchronous to CLK, active-low.
REQ-007 SHALL have port IN_SPI_DATA_READY  input  1  slave word-complete flag, asynchronous.
REQ-008 SHALL have port IN_SPI_RECEIVE_DATA  input  PACK_LENGTH  slave receive word, stable while IN_SPI_DATA_READY high.
REQ-009 SHALL have port OUT_DATA  output  PACK_LENGTH  FIFO head word.
REQ-010 SHALL have port OUT_VALID  output  1  FIFO not empty.
REQ-011 SHALL have port IN_READY  input  1  consumer accepts head.
REQ-012 SHALL have port OUT_FIFO_LEVEL  output  FIFO_DEPTH_LOG_2+1  entries held.
REQ-013 SHALL have port OUT_FRAME_END  output  1  one-cycle pulse at CS deassertion.
REQ-014 SHALL have port OUT_OVERFLOW  output  1  sticky word-dropped flag.
REQ-015 SHALL have port IN_CLEAR_OVERFLOW  input  1  clears OUT_OVERFLOW.
REQ-016 SHALL have, with SPI_BRIDGE_TX_PATH_EN only: IN_TX_DATA input PACK_LENGTH; IN_TX_LOAD input 1; OUT_TX_BUSY output 1; OUT_SPI_TRANSMIT_DATA output PACK_LENGTH (drives slave transmit input).

Function
REQ-017 SHALL synchronise IN_SPI_CS and IN_SPI_DATA_READY each through two flops plus one history flop.
REQ-018 SHALL write IN_SPI_RECEIVE_DATA into FIFO on the edge where synchronised DATA_READY is 1 and history is 0; OUT_VALID rises after 3rd CLK edge following DATA_READY rise (empty FIFO).
REQ-019 SHALL present head word combinationally on OUT_DATA (first-word fall-through); pop when OUT_VALID & IN_READY.
REQ-020 SHALL, on write while full without same-cycle pop, drop the word and set OUT_OVERFLOW; write while full with pop SHALL be accepted, level unchanged.
REQ-021 SHALL ignore IN_READY when empty; pointers wrap modulo FIFO_DEPTH.
REQ-022 SHALL pulse OUT_FRAME_END one cycle on synchronised CS 0->1.
REQ-023 SHALL clear OUT_OVERFLOW on IN_CLEAR_OVERFLOW; simultaneous set and clear SHALL leave it set.
REQ-024 SHALL (TX path) load OUT_SPI_TRANSMIT_DATA directly on IN_TX_LOAD when synchronised CS high; when CS low SHALL hold word in pending register, assert OUT_TX_BUSY, transfer in the OUT_FRAME_END cycle and deassert OUT_TX_BUSY next cycle; second load while busy SHALL overwrite pending word.
REQ-025 SHALL tolerate SCLK <= CLK/8 and DATA_READY high >= 3 CLK periods; faster input is unsupported.

Reset
REQ-026 SHALL, on IN_RESET, clear pointers, level, sync flops (CS sync to 1), OUT_VALID=0, OUT_FRAME_END=0, OUT_OVERFLOW=0, OUT_TX_BUSY=0, OUT_SPI_TRANSMIT_DATA=0; FIFO memory not reset.
REQ-027 SHALL discard an in-flight word and pending TX word when reset mid-frame; no OUT_FRAME_END from reset-forced CS sync value.

Configuration
REQ-028 SHALL compile TX holding path only when SPI_BRIDGE_TX_PATH_EN is defined; absent, TX ports and registers do not exist and receive behaviour is identical.

Structure
REQ-029 SHALL place PACK_LENGTH/FIFO_DEPTH defaults and sync-stage count constant in shared package spi_bridge_pkg.
REQ-030 SHALL implement FIFO as sub-module spi_bridge_fifo; synchroniser and TX logic stay in top.

Verification
REQ-031 Single word 0xA5, FIFO empty, IN_READY=0 -> OUT_VALID after 3rd edge, OUT_DATA=0xA5, level=1.
REQ-032 Five words 0x01..0x05, IN_READY=0, depth 4 -> level=4, OUT_OVERFLOW=1, pops yield 0x01..0x04.
REQ-033 Full FIFO, write 0x55 same cycle as pop -> level stays 4, 0x55 last read, no overflow.
REQ-034 CS low, two words, CS high -> exactly one OUT_FRAME_END pulse after both words written.
REQ-035 TX: load 0x3C with CS high -> OUT_SPI_TRANSMIT_DATA=0x3C next edge; load 0xC3 during frame -> OUT_TX_BUSY=1, value 0x3C until frame-end cycle, then 0xC3.
REQ-036 IN_RESET mid-frame with level=2 -> level=0, OUT_VALID=0, no OUT_FRAME_END, OUT_SPI_TRANSMIT_DATA=0.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg: shared constants for the SPI slave receive bridge.
//   PACK_LENGTH_DEF : default word width in bits
//   FIFO_DEPTH_DEF  : default receive FIFO depth (power of two, >= 2)
//   SYNC_STAGES     : flops in each CDC synchroniser chain (the edge-detect
//                     history flop comes after these)
package spi_bridge_pkg;
  localparam int PACK_LENGTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int SYNC_STAGES     = 2;
endpackage

// File: rtl/spi_bridge_fifo.sv
// spi_bridge_fifo: first-word fall-through FIFO for received SPI words.
// Ports:
//   clk, rst         : rising-edge clock, synchronous active-high reset
//   wr_en, wr_data   : write request; it is accepted when the FIFO is not full,
//                      or when it is full and a pop happens in the same cycle
//   rd_en            : pop request; it is ignored while the FIFO is empty
//   rd_data          : head word, driven combinationally
//   valid, full      : FIFO not empty / FIFO full
//   level            : number of entries held
// The storage array has no reset; only the pointers and the level are reset.
module spi_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full,
  output logic [PTR_W:0]   level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             push, pop;

  assign valid   = (level_q != '0);
  assign full    = (level_q == (PTR_W+1)'(DEPTH));
  assign level   = level_q;
  assign rd_data = mem[rd_ptr_q];

  // When the FIFO is full and a pop happens in the same cycle, the write
  // lands in the slot being freed. The popped word is still read out here
  // because rd_data is taken before the clock edge.
  assign pop  = rd_en & valid;
  assign push = wr_en & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Depth is a power of two, so natural pointer overflow gives the
    // wrap-around.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/spi_slave_rx_bridge.sv
// spi_slave_rx_bridge: moves words from an SPI slave core into the CLK domain
// and buffers them in a FIFO.
// Ports:
//   CLK, IN_RESET            : clock, synchronous active-high reset
//   IN_SPI_CS                : asynchronous chip select, active-low
//   IN_SPI_DATA_READY        : asynchronous word-complete flag
//   IN_SPI_RECEIVE_DATA      : received word, stable while DATA_READY is high
//   OUT_DATA/OUT_VALID       : FIFO head (first-word fall-through) / not empty
//   IN_READY                 : consumer pops the head when OUT_VALID is high
//   OUT_FIFO_LEVEL           : number of entries held
//   OUT_FRAME_END            : one-cycle pulse when the synchronised CS goes 0->1
//   OUT_OVERFLOW             : sticky flag, set when a word is dropped
//   IN_CLEAR_OVERFLOW        : clears the overflow flag; a drop in the same
//                              cycle wins and leaves the flag set
// Optional macro SPI_BRIDGE_TX_PATH_EN adds a TX holding path:
//   IN_TX_DATA, IN_TX_LOAD, OUT_TX_BUSY, OUT_SPI_TRANSMIT_DATA
module spi_slave_rx_bridge
  import spi_bridge_pkg::*;
#(
  parameter int PACK_LENGTH      = PACK_LENGTH_DEF,
  parameter int FIFO_DEPTH       = FIFO_DEPTH_DEF,
  parameter int FIFO_DEPTH_LOG_2 = $clog2(FIFO_DEPTH)
) (
  input  logic                      CLK,
  input  logic                      IN_RESET,
  input  logic                      IN_SPI_CS,
  input  logic                      IN_SPI_DATA_READY,
  input  logic [PACK_LENGTH-1:0]    IN_SPI_RECEIVE_DATA,
  output logic [PACK_LENGTH-1:0]    OUT_DATA,
  output logic                      OUT_VALID,
  input  logic                      IN_READY,
  output logic [FIFO_DEPTH_LOG_2:0] OUT_FIFO_LEVEL,
  output logic                      OUT_FRAME_END,
  output logic                      OUT_OVERFLOW,
  input  logic                      IN_CLEAR_OVERFLOW
`ifdef SPI_BRIDGE_TX_PATH_EN
  ,
  input  logic [PACK_LENGTH-1:0]    IN_TX_DATA,
  input  logic                      IN_TX_LOAD,
  output logic                      OUT_TX_BUSY,
  output logic [PACK_LENGTH-1:0]    OUT_SPI_TRANSMIT_DATA
`endif
);
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, rdy_sync_q, rdy_sync_d;
  logic cs_hist_q, cs_hist_d, rdy_hist_q, rdy_hist_d;
  logic ovf_q, ovf_d;
  logic cs_s, rdy_s, wr_pulse, fifo_full, drop;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign rdy_s    = rdy_sync_q[SYNC_STAGES-1];
  assign wr_pulse = rdy_s & ~rdy_hist_q;
  // On reset the CS chain and its history flop are both forced to 1, so the
  // reset value can never look like a 0->1 edge.
  assign OUT_FRAME_END = cs_s & ~cs_hist_q;
  assign drop          = wr_pulse & fifo_full & ~(IN_READY & OUT_VALID);
  assign OUT_OVERFLOW  = ovf_q;

  spi_bridge_fifo #(
    .WIDTH(PACK_LENGTH), .DEPTH(FIFO_DEPTH), .PTR_W(FIFO_DEPTH_LOG_2)
  ) u_fifo (
    .clk(CLK), .rst(IN_RESET),
    .wr_en(wr_pulse), .wr_data(IN_SPI_RECEIVE_DATA),
    .rd_en(IN_READY), .rd_data(OUT_DATA),
    .valid(OUT_VALID), .full(fifo_full), .level(OUT_FIFO_LEVEL)
  );

  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], IN_SPI_CS};
    rdy_sync_d = {rdy_sync_q[SYNC_STAGES-2:0], IN_SPI_DATA_READY};
    cs_hist_d  = cs_s;
    rdy_hist_d = rdy_s;
    ovf_d      = (ovf_q & ~IN_CLEAR_OVERFLOW) | drop;
  end

`ifdef SPI_BRIDGE_TX_PATH_EN
  logic [PACK_LENGTH-1:0] tx_data_q, tx_data_d, tx_pend_q, tx_pend_d;
  logic                   tx_busy_q, tx_busy_d;

  assign OUT_TX_BUSY           = tx_busy_q;
  assign OUT_SPI_TRANSMIT_DATA = tx_data_q;

  // The transmit word must not change in the middle of a frame. A load while
  // CS is low goes to the pending register and is moved across at frame end.
  // If a direct load arrives in the frame-end cycle, it is the newer word and
  // takes priority.
  always_comb begin
    tx_data_d = tx_data_q;
    tx_pend_d = tx_pend_q;
    tx_busy_d = tx_busy_q;
    if (OUT_FRAME_END && tx_busy_q) begin
      tx_data_d = tx_pend_q;
      tx_busy_d = 1'b0;
    end
    if (IN_TX_LOAD) begin
      if (cs_s) tx_data_d = IN_TX_DATA;
      else begin
        tx_pend_d = IN_TX_DATA;
        tx_busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (IN_RESET) begin
      tx_data_q <= '0;
      tx_pend_q <= '0;
      tx_busy_q <= 1'b0;
    end else begin
      tx_data_q <= tx_data_d;
      tx_pend_q <= tx_pend_d;
      tx_busy_q <= tx_busy_d;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (IN_RESET) begin
      cs_sync_q  <= '1;
      cs_hist_q  <= 1'b1;
      rdy_sync_q <= '0;
      rdy_hist_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cs_sync_q  <= cs_sync_d;
      cs_hist_q  <= cs_hist_d;
      rdy_sync_q <= rdy_sync_d;
      rdy_hist_q <= rdy_hist_d;
      ovf_q      <= ovf_d;
    end
  end
endmodule

// File: tb/tb_spi_slave_rx_bridge.sv
// Testbench for spi_slave_rx_bridge: table vectors, hand-written corner cases,
// and a randomized run checked against a queue-based FIFO model.
module tb_spi_slave_rx_bridge;
  localparam int W = 8, D = 4, LW = 2;

  logic         CLK = 1'b0;
  logic         IN_RESET, IN_SPI_CS, IN_SPI_DATA_READY, IN_READY, IN_CLEAR_OVERFLOW;
  logic [W-1:0] IN_SPI_RECEIVE_DATA, OUT_DATA;
  logic         OUT_VALID, OUT_FRAME_END, OUT_OVERFLOW;
  logic [LW:0]  OUT_FIFO_LEVEL;
  logic [W-1:0] IN_TX_DATA, OUT_SPI_TRANSMIT_DATA;
  logic         IN_TX_LOAD, OUT_TX_BUSY;

  always #5 CLK = ~CLK;

  spi_slave_rx_bridge #(.PACK_LENGTH(W), .FIFO_DEPTH(D), .FIFO_DEPTH_LOG_2(LW)) dut (
    .CLK(CLK), .IN_RESET(IN_RESET), .IN_SPI_CS(IN_SPI_CS),
    .IN_SPI_DATA_READY(IN_SPI_DATA_READY), .IN_SPI_RECEIVE_DATA(IN_SPI_RECEIVE_DATA),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .IN_READY(IN_READY),
    .OUT_FIFO_LEVEL(OUT_FIFO_LEVEL), .OUT_FRAME_END(OUT_FRAME_END),
    .OUT_OVERFLOW(OUT_OVERFLOW), .IN_CLEAR_OVERFLOW(IN_CLEAR_OVERFLOW)
`ifdef SPI_BRIDGE_TX_PATH_EN
    , .IN_TX_DATA(IN_TX_DATA), .IN_TX_LOAD(IN_TX_LOAD),
    .OUT_TX_BUSY(OUT_TX_BUSY), .OUT_SPI_TRANSMIT_DATA(OUT_SPI_TRANSMIT_DATA)
`endif
  );

  int n_chk = 0, n_pass = 0, fe_cnt = 0;

  always @(negedge CLK) if (OUT_FRAME_END === 1'b1) fe_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  // One word from the slave: DATA_READY is held high for 4 clocks, then low
  // for 3 clocks. The bridge writes the word on the 3rd edge.
  task automatic send_word(input logic [W-1:0] w);
    IN_SPI_RECEIVE_DATA = w;
    IN_SPI_DATA_READY = 1'b1;
    repeat (4) tick();
    IN_SPI_DATA_READY = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_pop(input logic [W-1:0] exp);
    check("pop_data", OUT_DATA, exp);
    IN_READY = 1'b1;
    tick();
    IN_READY = 1'b0;
  endtask

  typedef struct {logic [W-1:0] din; logic [LW:0] lvl; logic ovf;} vec_t;
  vec_t vt[5];

  logic [W-1:0] mq[$];
  logic         mo;

  initial begin
    for (int i = 0; i < 5; i++) begin
      vt[i].din = W'(i + 1);
      vt[i].lvl = (i < 4) ? (LW+1)'(i + 1) : (LW+1)'(4);
      vt[i].ovf = (i == 4);
    end

    IN_RESET = 1; IN_SPI_CS = 1; IN_SPI_DATA_READY = 0; IN_READY = 0;
    IN_CLEAR_OVERFLOW = 0; IN_SPI_RECEIVE_DATA = 0; IN_TX_DATA = 0; IN_TX_LOAD = 0;
    repeat (3) tick();
    check("rst_level", OUT_FIFO_LEVEL, 0);
    check("rst_valid", OUT_VALID, 0);
    check("rst_ovf", OUT_OVERFLOW, 0);
    check("rst_fe", OUT_FRAME_END, 0);
`ifdef SPI_BRIDGE_TX_PATH_EN
    check("rst_txd", OUT_SPI_TRANSMIT_DATA, 0);
    check("rst_busy", OUT_TX_BUSY, 0);
`endif
    IN_RESET = 0;
    tick();
    check("no_fe_after_rst", fe_cnt, 0);

    // A single word reaches the output after the 3rd edge.
    IN_SPI_RECEIVE_DATA = 8'hA5; IN_SPI_DATA_READY = 1;
    tick(); check("lat_e1", OUT_VALID, 0);
    tick(); check("lat_e2", OUT_VALID, 0);
    tick(); check("lat_e3", OUT_VALID, 1);
    check("lat_data", OUT_DATA, 8'hA5);
    check("lat_level", OUT_FIFO_LEVEL, 1);
    tick(); IN_SPI_DATA_READY = 0; repeat (3) tick();
    check("no_double_write", OUT_FIFO_LEVEL, 1);
    do_pop(8'hA5);
    check("pop_level0", OUT_FIFO_LEVEL, 0);

    // Five words into a 4-deep FIFO: the fifth is dropped and overflow is set.
    for (int i = 0; i < 5; i++) begin
      send_word(vt[i].din);
      check("tbl_level", OUT_FIFO_LEVEL, vt[i].lvl);
      check("tbl_ovf", OUT_OVERFLOW, vt[i].ovf);
    end
    for (int i = 0; i < 4; i++) do_pop(vt[i].din);
    check("tbl_empty", OUT_VALID, 0);
    IN_READY = 1; tick(); IN_READY = 0;
    check("pop_empty_level", OUT_FIFO_LEVEL, 0);
    check("ovf_sticky", OUT_OVERFLOW, 1);
    IN_CLEAR_OVERFLOW = 1; tick(); IN_CLEAR_OVERFLOW = 0;
    check("ovf_clear", OUT_OVERFLOW, 0);

    // Full FIFO: a write in the same cycle as a pop is accepted.
    for (int i = 0; i < 4; i++) send_word(W'(8'h11 + i));
    check("full_level", OUT_FIFO_LEVEL, 4);
    IN_SPI_RECEIVE_DATA = 8'h55; IN_SPI_DATA_READY = 1;
    tick(); tick();
    check("fp_head", OUT_DATA, 8'h11);
    IN_READY = 1; tick(); IN_READY = 0;
    check("fp_level", OUT_FIFO_LEVEL, 4);
    check("fp_ovf", OUT_OVERFLOW, 0);
    tick(); IN_SPI_DATA_READY = 0; repeat (3) tick();
    do_pop(8'h12); do_pop(8'h13); do_pop(8'h14); do_pop(8'h55);

    // A drop and a clear in the same cycle: the flag stays set.
    for (int i = 0; i < 4; i++) send_word(W'(8'h21 + i));
    IN_SPI_RECEIVE_DATA = 8'h66; IN_SPI_DATA_READY = 1;
    tick(); tick();
    IN_CLEAR_OVERFLOW = 1; tick(); IN_CLEAR_OVERFLOW = 0;
    check("ovf_set_wins", OUT_OVERFLOW, 1);
    check("ovf_set_level", OUT_FIFO_LEVEL, 4);
    tick(); IN_SPI_DATA_READY = 0; repeat (3) tick();
    IN_CLEAR_OVERFLOW = 1; tick(); IN_CLEAR_OVERFLOW = 0;
    check("ovf_clear2", OUT_OVERFLOW, 0);
    for (int i = 0; i < 4; i++) do_pop(W'(8'h21 + i));

    // Frame of two words: exactly one frame-end pulse, after both writes.
    fe_cnt = 0;
    IN_SPI_CS = 0; repeat (4) tick();
    send_word(8'h31); send_word(8'h32);
    check("fe_none_in_frame", fe_cnt, 0);
    IN_SPI_CS = 1; tick(); tick();
    check("fe_pulse", OUT_FRAME_END, 1);
    check("fe_level", OUT_FIFO_LEVEL, 2);
    repeat (5) tick();
    check("fe_count", fe_cnt, 1);
    do_pop(8'h31); do_pop(8'h32);

`ifdef SPI_BRIDGE_TX_PATH_EN
    IN_TX_DATA = 8'h3C; IN_TX_LOAD = 1; tick(); IN_TX_LOAD = 0;
    check("tx_direct", OUT_SPI_TRANSMIT_DATA, 8'h3C);
    check("tx_direct_busy", OUT_TX_BUSY, 0);
    IN_SPI_CS = 0; repeat (3) tick();
    IN_TX_DATA = 8'hC3; IN_TX_LOAD = 1; tick(); IN_TX_LOAD = 0;
    check("tx_busy", OUT_TX_BUSY, 1);
    check("tx_hold", OUT_SPI_TRANSMIT_DATA, 8'h3C);
    IN_SPI_CS = 1; tick();
    check("tx_hold2", OUT_SPI_TRANSMIT_DATA, 8'h3C);
    tick();
    check("tx_fe", OUT_FRAME_END, 1);
    check("tx_hold_fe", OUT_SPI_TRANSMIT_DATA, 8'h3C);
    check("tx_busy_fe", OUT_TX_BUSY, 1);
    tick();
    check("tx_xfer", OUT_SPI_TRANSMIT_DATA, 8'hC3);
    check("tx_busy_clr", OUT_TX_BUSY, 0);
`endif

    // Reset in the middle of a frame, with a word in flight.
    IN_SPI_CS = 0; repeat (4) tick();
`ifdef SPI_BRIDGE_TX_PATH_EN
    IN_TX_DATA = 8'h99; IN_TX_LOAD = 1; tick(); IN_TX_LOAD = 0;
`endif
    send_word(8'h41); send_word(8'h42);
    check("mr_level2", OUT_FIFO_LEVEL, 2);
    IN_SPI_RECEIVE_DATA = 8'h43; IN_SPI_DATA_READY = 1; tick();
    fe_cnt = 0;
    IN_RESET = 1; IN_SPI_DATA_READY = 0; tick();
    check("mr_level", OUT_FIFO_LEVEL, 0);
    check("mr_valid", OUT_VALID, 0);
    check("mr_fe", OUT_FRAME_END, 0);
`ifdef SPI_BRIDGE_TX_PATH_EN
    check("mr_txd", OUT_SPI_TRANSMIT_DATA, 0);
    check("mr_busy", OUT_TX_BUSY, 0);
`endif
    tick(); IN_RESET = 0; repeat (5) tick();
    check("mr_fe_cnt", fe_cnt, 0);
    check("mr_level_after", OUT_FIFO_LEVEL, 0);
    IN_SPI_CS = 1; repeat (4) tick();

    // Randomized run against a queue model of the FIFO.
    mq.delete(); mo = 0;
    for (int n = 0; n < 60; n++) begin
      int op;
      logic [W-1:0] w;
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        w = W'($urandom);
        send_word(w);
        if (mq.size() < D) mq.push_back(w); else mo = 1;
      end else if (op == 2) begin
        if (mq.size() != 0) begin
          do_pop(mq[0]);
          void'(mq.pop_front());
        end else begin
          IN_READY = 1; tick(); IN_READY = 0;
        end
      end else begin
        IN_CLEAR_OVERFLOW = 1; tick(); IN_CLEAR_OVERFLOW = 0;
        mo = 0;
      end
      check("rnd_level", OUT_FIFO_LEVEL, mq.size());
      check("rnd_valid", OUT_VALID, mq.size() != 0);
      check("rnd_ovf", OUT_OVERFLOW, mo);
      if (mq.size() != 0) check("rnd_head", OUT_DATA, mq[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
